sc_reg_reader: RTL and testbench
================================

# sc_reg_reader

Read-side companion to the general register bank. Accepts read requests by register address over a valid/ready handshake and samples the addressed register from the flattened bank bus. Returns data through a 2-entry response buffer so back-pressure from the datapath consumer never drops a read. It sits between the instruction decode stage, which issues source-operand reads, and the ALU operand latch.

## Interface
- DATAWIDTH_BUS, 32: width of each register and of the response data.
- NUM_REGS, 32: number of registers present on the bank bus.
- ADDRWIDTH, 5: width of request and write addresses; NUM_REGS ≤ 2^ADDRWIDTH.
- SC_RegREADER_CLOCK_50  in  1  single system clock; all state updates on its rising edge.
- SC_RegREADER_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_RegREADER_reqValid_In  in  1  request present.
- SC_RegREADER_reqAddr_In  in  ADDRWIDTH  register to read.
- SC_RegREADER_reqReady_Out  out  1  request accepted on this edge if valid.
- SC_RegREADER_bank_InBUS  in  NUM_REGS*DATAWIDTH_BUS  register k occupies bits [k*DATAWIDTH_BUS +: DATAWIDTH_BUS].
- SC_RegREADER_Write_InLow  in  1  bank write strobe, active-low; used for bypass only.
- SC_RegREADER_wrAddr_In  in  ADDRWIDTH  bank write address.
- SC_RegREADER_wrData_InBUS  in  DATAWIDTH_BUS  bank write data.
- SC_RegREADER_rspValid_Out  out  1  response present at buffer head.
- SC_RegREADER_rspData_OutBUS  out  DATAWIDTH_BUS  head data.
- SC_RegREADER_rspAddr_Out  out  ADDRWIDTH  head address.
- SC_RegREADER_rspErr_Out  out  1  head address was ≥ NUM_REGS.
- SC_RegREADER_rspReady_In  in  1  consumer accepts head on this edge.

## Operation
- Push: reqValid & reqReady at an edge. Pop: rspValid & rspReady at an edge.
- Occupancy FSM has three states: EMPTY, ONE and FULL.
  - EMPTY: push → ONE.
  - ONE: push with no pop → FULL; pop with no push → EMPTY; push and pop together → ONE, with the new entry becoming the head.
  - FULL: pop → ONE. A push cannot occur in FULL.
- reqReady = (state != FULL). It is registered-state only, with no combinational path from rspReady.
- rspValid = (state != EMPTY).
- Captured data at push:
  - Address 0 → all zeros (%r0 hard-wired).
  - Address ≥ NUM_REGS → all zeros, and the entry's err bit is set.
  - Otherwise → the bank slice at that address as present before the edge (subject to bypass, see Configuration).
- Entries are ordered FIFO. The head never changes while rspValid=1 and rspReady=0.
- Reset clears these, independent of the clock:
  - State → EMPTY.
  - rspValid=0, rspData=0, rspAddr=0, rspErr=0, reqReady=1.
- When reset asserts mid-operation, in-flight entries are discarded. No request is accepted while RESET_InLow=0.

## Timing
- Latency: a push at edge k into EMPTY gives rspValid=1 with its data during cycle k+1.
- Sustained throughput is 1 read per cycle when rspReady is held at 1.
- With rspReady held at 0:
  - 2 requests are accepted.
  - reqReady falls in the cycle after the second push.
  - It rises again in the cycle after the first pop.
- Bank sampling occurs at the push edge only. Later bank changes do not alter buffered entries.

## Configuration
- SC_REGREADER_BYPASS_EN defined:
  - Forwarding applies if, at the push edge, Write_InLow=0, wrAddr == reqAddr, and the address is nonzero and < NUM_REGS.
  - In that case the entry captures wrData_InBUS (read-after-write forwarding).
- SC_REGREADER_BYPASS_EN undefined:
  - The write ports are ignored.
  - The entry captures the pre-write bank value.

## Structure
- A shared package holds:
  - the state encoding constants: EMPTY=2'b00, ONE=2'b01, FULL=2'b10;
  - the zero-register index constant;
  - the response entry struct {data, addr, err}.
- One sub-module is natural: sc_reg_reader_select. It is combinational bank slice select plus zero/err/bypass logic, producing one entry from an address.
- The top level holds the FSM and the two entry registers.

## Test plan
- Reset: drive RESET_InLow=0 mid-stream with 2 entries buffered → rspValid=0, reqReady=1, rspData=0 immediately; after release, the first push at edge k gives rspValid in cycle k+1.
- Basic read: bank r5=32'hDEADBEEF, push addr 5 with rspReady=1 → next cycle rspValid=1, data 32'hDEADBEEF, addr 5, err 0.
- Zero and out of range (NUM_REGS=24): push addr 0 with r0 slice = 32'hFFFFFFFF → data 0, err 0; push addr 30 → data 0, err 1.
- Back-pressure: rspReady=0, push addr 1, 2, 3 on consecutive cycles → only 1 and 2 are accepted, reqReady=0 in FULL; raise rspReady → responses 1 then 2, then addr 3 is accepted.
- Simultaneous push/pop in ONE: stream addr 7, 8, 9 with rspReady=1 → state stays ONE and responses arrive in order, one per cycle.
- Bypass: r4=32'h11111111, Write_InLow=0, wrAddr=4, wrData=32'h22222222, push addr 4 on the same edge → 32'h22222222 with SC_REGREADER_BYPASS_EN defined, 32'h11111111 without.

Source files
------------

// File: rtl/sc_reg_reader_pkg.sv
// Shared definitions for the register-bank read port: occupancy state
// encoding, the hard-wired zero register index and the response entry layout.
package sc_reg_reader_pkg;

    // Entry field widths; the reader's DATAWIDTH_BUS/ADDRWIDTH default to these
    // and must be kept equal to them when overridden.
    localparam int RSP_DATA_W   = 32;
    localparam int RSP_ADDR_W   = 5;

    // %r0 always reads as zero regardless of what the bank bus carries.
    localparam int ZERO_REG_IDX = 0;

    // Occupancy of the 2-entry response buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // One buffered read response.
    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic [RSP_ADDR_W-1:0] addr;
        logic                  err;
    } rsp_entry_t;

endpackage : sc_reg_reader_pkg

// File: rtl/sc_reg_reader_select.sv
// Combinational entry builder: picks the addressed slice from the flattened
// register bank and applies the zero-register, out-of-range and (optionally,
// when SC_REGREADER_BYPASS_EN is defined) read-after-write forwarding rules.
module sc_reg_reader_select
    import sc_reg_reader_pkg::*;
#(
    parameter int DATAWIDTH_BUS = RSP_DATA_W,
    parameter int NUM_REGS      = 32,
    parameter int ADDRWIDTH     = RSP_ADDR_W
) (
    input  logic [ADDRWIDTH-1:0]              i_addr,
    input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] i_bank,
    input  logic                              i_wr_n,
    input  logic [ADDRWIDTH-1:0]              i_wr_addr,
    input  logic [DATAWIDTH_BUS-1:0]          i_wr_data,
    output rsp_entry_t                        o_entry
);

    // NUM_REGS <= 2^ADDRWIDTH, so one extra bit holds it without truncation.
    localparam logic [ADDRWIDTH:0] LP_NUM_REGS = (ADDRWIDTH+1)'(NUM_REGS);

    int         w_idx;
    logic       w_out_of_range;
    logic       w_is_zero;
    rsp_entry_t w_entry;

    assign w_idx          = int'(i_addr);
    assign w_out_of_range = ({1'b0, i_addr} >= LP_NUM_REGS);
    assign w_is_zero      = (i_addr == ADDRWIDTH'(ZERO_REG_IDX));

`ifndef SC_REGREADER_BYPASS_EN
    // Write port has no effect without forwarding; fold it into a sink.
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_n, i_wr_addr, i_wr_data};
`endif

    // Build the entry for i_addr: error/zero first, then bank (or forwarded) data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, otherwise a missed path would infer a latch.
        w_entry      = '0;
        w_entry.addr = i_addr;
        if (w_out_of_range) begin
            w_entry.err = 1'b1;
        end else if (w_is_zero) begin
            w_entry.data = '0;
`ifdef SC_REGREADER_BYPASS_EN
        end else if (!i_wr_n && (i_wr_addr == i_addr)) begin
            w_entry.data = i_wr_data;
`endif
        end else begin
            w_entry.data = i_bank[w_idx*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        end
    end

    assign o_entry = w_entry;

endmodule : sc_reg_reader_select

// File: rtl/sc_reg_reader.sv
// Register-bank read port with a 2-entry response buffer between decode and the
// ALU operand latch. Requests are accepted on a valid/ready handshake; the
// response buffer absorbs consumer back-pressure without dropping reads.
// Optional read-after-write forwarding: define SC_REGREADER_BYPASS_EN.
module sc_reg_reader
    import sc_reg_reader_pkg::*;
#(
    parameter int DATAWIDTH_BUS = RSP_DATA_W,
    parameter int NUM_REGS      = 32,
    parameter int ADDRWIDTH     = RSP_ADDR_W
) (
    input  logic                              SC_RegREADER_CLOCK_50,
    input  logic                              SC_RegREADER_RESET_InLow,
    input  logic                              SC_RegREADER_reqValid_In,
    input  logic [ADDRWIDTH-1:0]              SC_RegREADER_reqAddr_In,
    output logic                              SC_RegREADER_reqReady_Out,
    input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegREADER_bank_InBUS,
    input  logic                              SC_RegREADER_Write_InLow,
    input  logic [ADDRWIDTH-1:0]              SC_RegREADER_wrAddr_In,
    input  logic [DATAWIDTH_BUS-1:0]          SC_RegREADER_wrData_InBUS,
    output logic                              SC_RegREADER_rspValid_Out,
    output logic [DATAWIDTH_BUS-1:0]          SC_RegREADER_rspData_OutBUS,
    output logic [ADDRWIDTH-1:0]              SC_RegREADER_rspAddr_Out,
    output logic                              SC_RegREADER_rspErr_Out,
    input  logic                              SC_RegREADER_rspReady_In
);

    state_e     r_state;
    state_e     w_state_next;
    rsp_entry_t r_head;
    rsp_entry_t r_tail;
    rsp_entry_t w_new_entry;

    logic w_push;
    logic w_pop;
    logic w_load_head;
    logic w_head_from_tail;
    logic w_load_tail;

    // Entry the current request would capture on this edge.
    sc_reg_reader_select #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS),
        .NUM_REGS      (NUM_REGS),
        .ADDRWIDTH     (ADDRWIDTH)
    ) u_select (
        .i_addr    (SC_RegREADER_reqAddr_In),
        .i_bank    (SC_RegREADER_bank_InBUS),
        .i_wr_n    (SC_RegREADER_Write_InLow),
        .i_wr_addr (SC_RegREADER_wrAddr_In),
        .i_wr_data (SC_RegREADER_wrData_InBUS),
        .o_entry   (w_new_entry)
    );

    // Ready depends on registered state only, so the consumer's ready never
    // ripples combinationally back to the decode stage.
    assign SC_RegREADER_reqReady_Out = (r_state != ST_FULL);
    assign SC_RegREADER_rspValid_Out = (r_state != ST_EMPTY);

    assign w_push = SC_RegREADER_reqValid_In & SC_RegREADER_reqReady_Out;
    assign w_pop  = SC_RegREADER_rspValid_Out & SC_RegREADER_rspReady_In;

    // Occupancy state register.
    always_ff @(posedge SC_RegREADER_CLOCK_50 or negedge SC_RegREADER_RESET_InLow) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // updates from pre-edge values, independent of statement order.
        if (!SC_RegREADER_RESET_InLow) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy and which entry register loads from where.
    always_comb begin
        w_state_next     = r_state;
        w_load_head      = 1'b0;
        w_head_from_tail = 1'b0;
        w_load_tail      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_ONE;
                    w_load_head  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head = 1'b1;
                end else if (w_push) begin
                    w_state_next = ST_FULL;
                    w_load_tail  = 1'b1;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next     = ST_ONE;
                    w_load_head      = 1'b1;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Head/tail entry registers; the head only moves on a load, so it holds
    // steady while the consumer stalls.
    always_ff @(posedge SC_RegREADER_CLOCK_50 or negedge SC_RegREADER_RESET_InLow) begin
        // NOTE: only two entries, and the head drives the outputs directly, so
        // both are reset to give defined zeros on the response bus after reset.
        if (!SC_RegREADER_RESET_InLow) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_head_from_tail ? r_tail : w_new_entry;
            end
            if (w_load_tail) begin
                r_tail <= w_new_entry;
            end
        end
    end

    assign SC_RegREADER_rspData_OutBUS = r_head.data;
    assign SC_RegREADER_rspAddr_Out    = r_head.addr;
    assign SC_RegREADER_rspErr_Out     = r_head.err;

endmodule : sc_reg_reader

// File: tb/tb_sc_reg_reader.sv
// Bench for sc_reg_reader with a 24-register bank: directed vector table,
// hand-written bypass/reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_sc_reg_reader;

    localparam int DW = 32;
    localparam int NR = 24;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [AW-1:0]     req_addr;
    logic              req_ready;
    logic [NR*DW-1:0]  bank_bus;
    logic              wr_n;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     rsp_addr;
    logic              rsp_err;
    logic              rsp_ready;

    logic [DW-1:0]     bank_mem [NR];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        bank_bus = '0;
        for (int k = 0; k < NR; k++) bank_bus[k*DW +: DW] = bank_mem[k];
    end

    sc_reg_reader #(
        .DATAWIDTH_BUS (DW),
        .NUM_REGS      (NR),
        .ADDRWIDTH     (AW)
    ) dut (
        .SC_RegREADER_CLOCK_50       (clk),
        .SC_RegREADER_RESET_InLow    (rst_n),
        .SC_RegREADER_reqValid_In    (req_valid),
        .SC_RegREADER_reqAddr_In     (req_addr),
        .SC_RegREADER_reqReady_Out   (req_ready),
        .SC_RegREADER_bank_InBUS     (bank_bus),
        .SC_RegREADER_Write_InLow    (wr_n),
        .SC_RegREADER_wrAddr_In      (wr_addr),
        .SC_RegREADER_wrData_InBUS   (wr_data),
        .SC_RegREADER_rspValid_Out   (rsp_valid),
        .SC_RegREADER_rspData_OutBUS (rsp_data),
        .SC_RegREADER_rspAddr_Out    (rsp_addr),
        .SC_RegREADER_rspErr_Out     (rsp_err),
        .SC_RegREADER_rspReady_In    (rsp_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rval(input int k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    task automatic init_bank();
        for (int k = 0; k < NR; k++) bank_mem[k] = rval(k);
        bank_mem[0] = 32'hFFFF_FFFF;
        bank_mem[4] = 32'h1111_1111;
        bank_mem[5] = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic        r;
        logic        e_valid;
        logic        e_ready;
        logic        chk_head;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic v, input int a, input logic r,
                                input logic ev, input logic er, input logic ch,
                                input logic [31:0] ed, input int ea, input logic ee);
        vec_t t;
        t.v = v; t.a = 5'(a); t.r = r;
        t.e_valid = ev; t.e_ready = er; t.chk_head = ch;
        t.e_data = ed; t.e_addr = 5'(ea); t.e_err = ee;
        return t;
    endfunction

    vec_t tbl [15];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        err;
    } m_entry_t;

    m_entry_t m_q [$];

    // What a read of addr must return given the bank and write port right now.
    function automatic m_entry_t model_entry(input int addr);
        m_entry_t e;
        e.addr = 5'(addr);
        e.err  = 1'b0;
        e.data = '0;
        if (addr >= NR) begin
            e.err = 1'b1;
        end else if (addr == 0) begin
            e.data = '0;
        end else begin
            e.data = bank_mem[addr];
`ifdef SC_REGREADER_BYPASS_EN
            if (!wr_n && int'(wr_addr) == addr) e.data = wr_data;
`endif
        end
        return e;
    endfunction

    logic [31:0] exp_bypass;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wr_n      = 1'b1;
        wr_addr   = '0;
        wr_data   = '0;
        init_bank();
        #2;
        check("reset_rspValid", 32'(rsp_valid), 32'd0);
        check("reset_reqReady", 32'(req_ready), 32'd1);
        check("reset_rspData",  rsp_data, 32'd0);
        check("reset_rspAddr",  32'(rsp_addr), 32'd0);
        check("reset_rspErr",   32'(rsp_err), 32'd0);
        tick();
        rst_n = 1'b1;

        // v  a  r   ev er ch  data            addr err
        tbl[0]  = mk(1, 5, 1,  1, 1, 1, 32'hDEAD_BEEF, 5,  0);
        tbl[1]  = mk(1, 0, 1,  1, 1, 1, 32'h0,         0,  0);
        tbl[2]  = mk(1, 30, 1, 1, 1, 1, 32'h0,         30, 1);
        tbl[3]  = mk(0, 0, 1,  0, 1, 0, 32'h0,         0,  0);
        tbl[4]  = mk(1, 1, 0,  1, 1, 1, rval(1),       1,  0);
        tbl[5]  = mk(1, 2, 0,  1, 0, 1, rval(1),       1,  0);
        tbl[6]  = mk(1, 3, 0,  1, 0, 1, rval(1),       1,  0);
        tbl[7]  = mk(1, 3, 1,  1, 1, 1, rval(2),       2,  0);
        tbl[8]  = mk(1, 3, 1,  1, 1, 1, rval(3),       3,  0);
        tbl[9]  = mk(0, 0, 0,  1, 1, 1, rval(3),       3,  0);
        tbl[10] = mk(0, 0, 1,  0, 1, 0, 32'h0,         0,  0);
        tbl[11] = mk(1, 7, 1,  1, 1, 1, rval(7),       7,  0);
        tbl[12] = mk(1, 8, 1,  1, 1, 1, rval(8),       8,  0);
        tbl[13] = mk(1, 9, 1,  1, 1, 1, rval(9),       9,  0);
        tbl[14] = mk(0, 0, 1,  0, 1, 0, 32'h0,         0,  0);

        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            req_addr  = tbl[i].a;
            rsp_ready = tbl[i].r;
            tick();
            check($sformatf("tbl%0d_rspValid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_reqReady", i), 32'(req_ready), 32'(tbl[i].e_ready));
            if (tbl[i].chk_head) begin
                check($sformatf("tbl%0d_rspData", i), rsp_data, tbl[i].e_data);
                check($sformatf("tbl%0d_rspAddr", i), 32'(rsp_addr), 32'(tbl[i].e_addr));
                check($sformatf("tbl%0d_rspErr", i),  32'(rsp_err), 32'(tbl[i].e_err));
            end
        end

        // ---------------- bypass on the push edge ----------------
`ifdef SC_REGREADER_BYPASS_EN
        exp_bypass = 32'h2222_2222;
`else
        exp_bypass = 32'h1111_1111;
`endif
        wr_n = 1'b0; wr_addr = 5'd4; wr_data = 32'h2222_2222;
        req_valid = 1'b1; req_addr = 5'd4; rsp_ready = 1'b0;
        tick();
        check("bypass_r4_data", rsp_data, exp_bypass);
        // Later bank change must not alter the buffered entry.
        wr_n = 1'b1;
        req_addr = 5'd6;
        tick();
        check("full_reqReady", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        bank_mem[6] = 32'h5555_5555;
        rsp_ready = 1'b1;
        tick();
        check("stale_r6_addr", 32'(rsp_addr), 32'd6);
        check("stale_r6_data", rsp_data, rval(6));
        tick();
        check("drain_rspValid", 32'(rsp_valid), 32'd0);
        // Forwarding never applies to r0, nor when write address differs.
        wr_n = 1'b0; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        req_valid = 1'b1; req_addr = 5'd0;
        tick();
        check("bypass_r0_data", rsp_data, 32'd0);
        wr_addr = 5'd5; wr_data = 32'h3333_3333; req_addr = 5'd4;
        tick();
        check("bypass_miss_data", rsp_data, 32'h1111_1111);
        wr_n = 1'b1; req_valid = 1'b0;
        tick();
        bank_mem[6] = rval(6);

        // ---------------- asynchronous reset mid-stream ----------------
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 5'd10;
        tick();
        req_addr = 5'd11;
        tick();
        check("prereset_full", 32'(req_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rspValid", 32'(rsp_valid), 32'd0);
        check("async_rst_reqReady", 32'(req_ready), 32'd1);
        check("async_rst_rspData",  rsp_data, 32'd0);
        check("async_rst_rspAddr",  32'(rsp_addr), 32'd0);
        tick();
        check("in_rst_no_accept", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1; req_valid = 1'b0;
        tick();
        check("post_rst_empty", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_addr = 5'd5;
        tick();
        check("post_rst_latency_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_latency_data", rsp_data, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        do_reset();

        // ---------------- randomized traffic vs. model ----------------
        m_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_entry_t nxt;
            logic     m_push;
            logic     m_pop;
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 5'($urandom_range(0, 31));
            rsp_ready = ($urandom_range(0, 2) != 0);
            wr_n      = ($urandom_range(0, 2) == 0);
            wr_addr   = ($urandom_range(0, 1) != 0) ? req_addr : 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            nxt    = model_entry(int'(req_addr));
            m_push = req_valid && (m_q.size() < 2);
            m_pop  = rsp_ready && (m_q.size() > 0);
            tick();
            // The bank itself takes the write on this edge.
            if (!wr_n && int'(wr_addr) != 0 && int'(wr_addr) < NR) bank_mem[wr_addr] = wr_data;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(nxt);
            check("rnd_rspValid", 32'(rsp_valid), 32'(m_q.size() > 0));
            check("rnd_reqReady", 32'(req_ready), 32'(m_q.size() < 2));
            if (m_q.size() > 0) begin
                check("rnd_rspData", rsp_data, m_q[0].data);
                check("rnd_rspAddr", 32'(rsp_addr), 32'(m_q[0].addr));
                check("rnd_rspErr",  32'(rsp_err), 32'(m_q[0].err));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sc_reg_reader
